// File: rtl/mw_adder_pkg.sv
// Shared definitions for the multi-word adder controller: FSM state
// encodings and the signed-overflow rule used when a result completes.
package mw_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_v.sv
// One slice of the shared adder datapath: DATA_WIDTH-bit add with carry
// in and carry out. The controller reuses this slice once per word.
module adder_v #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  ci,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  co
);

    logic [DATA_WIDTH:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, ci};
    assign {co, s} = total_s;

endmodule

// File: rtl/mw_adder_ctrl_v.sv
// Multi-word adder/subtractor controller. An accepted request is processed
// one DATA_WIDTH slice per cycle through a single shared adder_v, least
// significant slice first, with the carry rippling through a register.
// Subtraction is performed as A + ~B + 1. The result is presented with a
// valid/ready handshake and held until consumed, then kept in IDLE.
module mw_adder_ctrl_v
    import mw_adder_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_WORDS  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]   A,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]   B,
    input  logic                              Ci,
    input  logic                              sub,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH*NUM_WORDS-1:0]   Sum,
    output logic                              Cout,
    output logic                              Ovf
);

    localparam int W     = DATA_WIDTH * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IDX_W-1:0]        idx_r;
    logic                    carry_r;
    logic [W-1:0]            a_r;
    logic [W-1:0]            b_r;
    logic [W-1:0]            sum_r;
    logic                    cout_r;
    logic                    ovf_r;
    logic                    in_ready_r;
    logic                    out_valid_r;

    logic                    accept_s;
    logic                    last_s;
    logic [DATA_WIDTH-1:0]   slice_a_s;
    logic [DATA_WIDTH-1:0]   slice_b_s;
    logic [DATA_WIDTH-1:0]   slice_sum_s;
    logic                    slice_co_s;

    // Current slice of the registered operands feeding the shared adder.
    assign slice_a_s = a_r[idx_r*DATA_WIDTH +: DATA_WIDTH];
    assign slice_b_s = b_r[idx_r*DATA_WIDTH +: DATA_WIDTH];

    adder_v #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .ci (carry_r),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == LAST_IDX) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with handshake flags registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand capture on accept, slice-serial accumulation in RUN, flags on the last slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= A;
                        b_r     <= sub ? ~B : B;
                        carry_r <= sub ? 1'b1 : Ci;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    sum_r[idx_r*DATA_WIDTH +: DATA_WIDTH] <= slice_sum_s;
                    carry_r <= slice_co_s;
                    idx_r   <= idx_r + IDX_ONE;
                    if (last_s) begin
                        cout_r <= slice_co_s;
                        ovf_r  <= signed_ovf(a_r[W-1], b_r[W-1], slice_sum_s[DATA_WIDTH-1]);
                    end
                end
                DONE: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign Sum       = sum_r;
    assign Cout      = cout_r;
    assign Ovf       = ovf_r;

endmodule

// File: tb/tb_mw_adder_ctrl_v.sv
// Bench for mw_adder_ctrl_v: directed corner cases plus random operations,
// each result compared with an arithmetic reference model.
module tb_mw_adder_ctrl_v;

    localparam int DW = 4;
    localparam int NW = 4;
    localparam int W  = DW * NW;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cnt = 0;

    mw_adder_ctrl_v #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Ci        (Ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counts requests that will be taken at the coming rising edge.
    always @(negedge clk) begin
        if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

    // Reference: {cout, ovf, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        longint ua, ub, sa, sb, cl, ures, sres;
        logic co, ov;
        logic [W-1:0] sm;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        cl = c;
        if (s) begin
            ures = ua - ub;
            sres = sa - sb;
            co   = (ua >= ub);
        end else begin
            ures = ua + ub + cl;
            sres = sa + sb + cl;
            co   = (ures >= (64'sd1 <<< W));
        end
        sm = ures[W-1:0];
        ov = (sres > ((64'sd1 <<< (W-1)) - 64'sd1)) || (sres < -(64'sd1 <<< (W-1)));
        return {co, ov, sm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s);
        @(posedge clk); #1;
        A = a; B = b; Ci = c; sub = s; in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        chk("accept_ready", in_ready, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); Ci = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_result(input logic [W+1:0] e, input string tag);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 30);
        chk({tag, "_latency"}, lat, NW + 1);
        chk({tag, "_sum"}, Sum, e[W-1:0]);
        chk({tag, "_cout"}, Cout, e[W+1]);
        chk({tag, "_ovf"}, Ovf, e[W]);
        chk({tag, "_busy"}, in_ready, 32'd0);
    endtask

    task automatic hold_check(input logic [W+1:0] e, input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 32'd1);
            chk({tag, "_hold_ready"}, in_ready, 32'd0);
            chk({tag, "_hold_sum"}, Sum, e[W-1:0]);
            chk({tag, "_hold_flags"}, {Cout, Ovf}, e[W+1:W]);
        end
    endtask

    task automatic release_result(input logic [W+1:0] e, input string tag);
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, out_valid, 32'd0);
        chk({tag, "_idle_ready"}, in_ready, 32'd1);
        chk({tag, "_idle_sum"}, Sum, e[W-1:0]);
    endtask

    initial begin
        logic [W+1:0] e1, e2;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           acc0, stale, c_prev, c_now;
        logic [W-1:0] ba [3];
        logic [W-1:0] bb [3];
        logic         bs [3];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Ci = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_sum", Sum, 32'd0);
        chk("rst_flags", {Cout, Ovf}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Carry ripples through all slices.
        e1 = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("model_ripple", e1, {1'b1, 1'b0, 16'h0000});
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result(e1, "ripple");
        release_result(e1, "ripple");

        // Subtract with borrow.
        e1 = model(16'h0005, 16'h0007, 1'b0, 1'b1);
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_result(e1, "borrow");
        chk("borrow_exact", {Cout, Ovf, Sum}, {1'b0, 1'b0, 16'hFFFE});
        release_result(e1, "borrow");

        // Signed overflow on add and on subtract.
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_result({1'b0, 1'b1, 16'h8000}, "ovf_add");
        release_result({1'b0, 1'b1, 16'h8000}, "ovf_add");
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_result({1'b1, 1'b1, 16'h7FFF}, "ovf_sub");
        release_result({1'b1, 1'b1, 16'h7FFF}, "ovf_sub");

        // Backpressure with a second request waiting.
        e1 = model(16'h1234, 16'h4321, 1'b1, 1'b0);
        e2 = model(16'hA5A5, 16'h0F0F, 1'b0, 1'b1);
        start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_result(e1, "bp1");
        @(posedge clk); #1;
        A = 16'hA5A5; B = 16'h0F0F; Ci = 1'b0; sub = 1'b1; in_valid = 1'b1;
        acc0 = acc_cnt;
        hold_check(e1, 3, "bp1");
        @(posedge clk); #1;
        chk("bp_no_accept", acc_cnt, acc0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after", in_ready, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept_once", acc_cnt, acc0 + 1);
        wait_result(e2, "bp2");
        release_result(e2, "bp2");

        // Reset in the middle of an operation.
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 32'd1);
        chk("mid_rst_out_valid", out_valid, 32'd0);
        chk("mid_rst_sum", Sum, 32'd0);
        chk("mid_rst_flags", {Cout, Ovf}, 32'd0);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("mid_rst_no_stale", stale, 32'd0);

        // Back-to-back with in_valid and out_ready held high.
        for (int i = 0; i < 3; i++) begin
            ba[i] = W'($urandom); bb[i] = W'($urandom); bs[i] = 1'($urandom);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1;
        A = ba[0]; B = bb[0]; Ci = 1'b1; sub = bs[0];
        c_prev = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
            chk("b2b_ready", in_ready, 32'd1);
            c_now = cyc;
            if (i > 0) chk("b2b_spacing", c_now - c_prev, NW + 2);
            c_prev = c_now;
            @(posedge clk); #1;
            if (i < 2) begin
                A = ba[i+1]; B = bb[i+1]; Ci = 1'b1; sub = bs[i+1];
            end else begin
                in_valid = 1'b0;
            end
            wait_result(model(ba[i], bb[i], 1'b1, bs[i]), "b2b");
        end
        @(posedge clk); #1; out_ready = 1'b0;

        // Random operations with random backpressure.
        for (int n = 0; n < 16; n++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (n == 0) begin ra = 16'h0000; rb = 16'h8000; rs = 1'b1; end
            e1 = model(ra, rb, rc, rs);
            start_op(ra, rb, rc, rs);
            wait_result(e1, "rnd");
            hold_check(e1, $urandom_range(0, 2), "rnd");
            release_result(e1, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mw_adder_ctrl_v.md
MW_ADDER_CTRL_V -- requirements
Module: mw_adder_ctrl_v

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: slice width of the shared adder datapath; legal values are at least 2.
REQ-002 SHALL have parameter NUM_WORDS, default 4: number of slices per operation; legal values are at least 1; operand width is W = DATA_WIDTH*NUM_WORDS.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation request is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller can accept a request.
REQ-007 SHALL have port A, input, W bits: first operand.
REQ-008 SHALL have port B, input, W bits: second operand.
REQ-009 SHALL have port Ci, input, 1 bit: carry-in for add; ignored for subtract.
REQ-010 SHALL have port sub, input, 1 bit: 0 = A+B+Ci, 1 = A-B.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port Sum, output, W bits: result.
REQ-014 SHALL have port Cout, output, 1 bit: carry out of bit W-1 (for subtract, 1 = no borrow).
REQ-015 SHALL have port Ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL drive out_valid = 1 only in DONE.
REQ-019 SHALL, on accept (in_valid & in_ready in cycle T), register A, B' = sub ? ~B : B, and carry = sub ? 1 : Ci; it SHALL then clear the slice index and move IDLE -> RUN.
REQ-020 SHALL, in RUN, add slice idx of A and B' plus the carry register each cycle, write the result into Sum slice idx, load the slice carry-out into the carry register, and increment idx.
REQ-021 SHALL move RUN -> DONE in the cycle where idx = NUM_WORDS-1; NUM_WORDS = 1 gives exactly one RUN cycle.
REQ-022 SHALL raise out_valid in cycle T+NUM_WORDS+1; for DATA_WIDTH = 4 and NUM_WORDS = 4 that is T+5.
REQ-023 SHALL, in DONE, set Cout = final carry and Ovf = (A[W-1] == B'[W-1]) & (Sum[W-1] != A[W-1]).
REQ-024 SHALL hold Sum, Cout and Ovf stable while out_valid & ~out_ready.
REQ-025 SHALL move DONE -> IDLE on out_valid & out_ready; the next accept is possible one cycle later, so the minimum spacing between accepts is NUM_WORDS+2 cycles.
REQ-026 SHALL ignore in_valid in RUN and DONE; operand inputs SHALL be don't-care outside the accept cycle.
REQ-027 SHALL keep Sum, Cout and Ovf unchanged in IDLE, holding the last result.

Reset
REQ-028 SHALL, when rst = 1, force state IDLE, idx = 0, carry = 0, Sum = 0, Cout = 0, Ovf = 0, out_valid = 0 and in_ready = 1 on the next edge.
REQ-029 SHALL, on reset in RUN or DONE, discard the operation in progress without presenting it; reset SHALL take priority over every handshake in the same cycle.

Structure
REQ-030 SHALL take its state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) from the shared package/include mw_adder_pkg.
REQ-031 SHALL instantiate exactly one adder_v with DATA_WIDTH = DATA_WIDTH as the slice datapath; no other arithmetic on the operands SHALL be inferred.

Verification
REQ-032 SHALL cover add with carry ripple: DATA_WIDTH = 4, NUM_WORDS = 4, A = 0xFFFF, B = 0x0001, Ci = 0 -> Sum = 0x0000, Cout = 1, Ovf = 0, out_valid exactly at T+5.
REQ-033 SHALL cover subtract with borrow: A = 0x0005, B = 0x0007, sub = 1 -> Sum = 0xFFFE, Cout = 0, Ovf = 0.
REQ-034 SHALL cover signed overflow: A = 0x7FFF, B = 0x0001, Ci = 0 -> Sum = 0x8000, Ovf = 1, Cout = 0; and A = 0x8000, B = 0x0001, sub = 1 -> Sum = 0x7FFF, Ovf = 1.
REQ-035 SHALL cover backpressure: hold out_ready = 0 for 3 cycles in DONE -> Sum/Cout/Ovf stable and in_ready = 0; a second in_valid asserted meanwhile is not accepted and is accepted only after out_ready.
REQ-036 SHALL cover reset mid-operation: rst = 1 in cycle T+2 -> next cycle in_ready = 1, out_valid = 0, Sum = 0, and no stale result is presented afterward.
REQ-037 SHALL cover back-to-back operation: in_valid and out_ready held high over 3 operations -> accepts exactly 6 cycles apart, each result correct.
